// File: rtl/calc_display.sv
// Sequential double-dabble binary-to-BCD converter driving eight active-low 7-segment displays.
// Optional leading-zero blanking is enabled by defining CALC_DISPLAY_LZ_BLANK_EN.
module calc_display #(
  parameter int BIN_W    = 27,
  parameter int NUM_DISP = 8,
  parameter int BCD_DIG  = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [BIN_W-1:0] digits,
  input  logic [1:0]       status,
  output logic [6:0]       displays [NUM_DISP],
  output logic             busy,
  output logic             overflow
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;

  localparam logic [1:0] ST_ERROR = 2'b10;

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam int BCD_W = 4 * BCD_DIG;

  logic [1:0]       state;
  logic [BIN_W-1:0] shift_reg;
  logic [BCD_W-1:0] bcd;
  logic [BCD_W-1:0] bcd_adj;
  logic [4:0]       cnt;
  logic [BIN_W-1:0] last_digits;
  logic [1:0]       last_status;
  logic [6:0]       num_disp [NUM_DISP];

  function automatic logic [6:0] seg_code(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  // Add-3 correction applied to each nibble before the shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < BCD_DIG; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Numeric display patterns; blanking scans from the most-significant digit down
  always_comb begin
    logic seen;
    seen = 1'b0;
    for (int i = NUM_DISP - 1; i >= 0; i--) begin
      num_disp[i] = seg_code(bcd[4*i +: 4]);
      if (bcd[4*i +: 4] != 4'd0)
        seen = 1'b1;
`ifdef CALC_DISPLAY_LZ_BLANK_EN
      if (!seen && i != 0)
        num_disp[i] = SEG_BLANK;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      overflow    <= 1'b0;
      last_digits <= '0;
      last_status <= 2'b00;
      shift_reg   <= '0;
      bcd         <= '0;
      cnt         <= '0;
      for (int i = 0; i < NUM_DISP; i++) begin
`ifdef CALC_DISPLAY_LZ_BLANK_EN
        displays[i] <= (i == 0) ? SEG_ZERO : SEG_BLANK;
`else
        displays[i] <= SEG_ZERO;
`endif
      end
    end else begin
      case (state)
        IDLE: begin
          if (digits != last_digits || status != last_status) begin
            shift_reg   <= digits;
            last_digits <= digits;
            last_status <= status;
            bcd         <= '0;
            cnt         <= '0;
            state       <= SHIFT;
            busy        <= 1'b1;
          end
        end
        SHIFT: begin
          bcd       <= {bcd_adj[BCD_W-2:0], shift_reg[BIN_W-1]};
          shift_reg <= {shift_reg[BIN_W-2:0], 1'b0};
          cnt       <= cnt + 5'd1;
          if (cnt == 5'(BIN_W - 1))
            state <= LOAD;
        end
        LOAD: begin
          // The ninth nibble is nonzero exactly when the value exceeds 99_999_999
          if (last_status == ST_ERROR) begin
            overflow <= 1'b0;
            for (int i = 0; i < NUM_DISP; i++) displays[i] <= SEG_DASH;
          end else if (bcd[BCD_W-1 -: 4] != 4'd0) begin
            overflow <= 1'b1;
            for (int i = 0; i < NUM_DISP; i++) displays[i] <= SEG_DASH;
          end else begin
            overflow <= 1'b0;
            for (int i = 0; i < NUM_DISP; i++) displays[i] <= num_disp[i];
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
